// File: rtl/frame_buffer_ctrl_if.sv
// ============================================================================
// Module   : frame_buffer_ctrl_if
// Purpose  : Drawer write port, scan-out read port and SRAM port of the
//            double-buffered frame-buffer controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface frame_buffer_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              wr_valid;
    logic              wr_ready;
    logic [9:0]        wr_x;
    logic [9:0]        wr_y;
    logic [7:0]        wr_color;
    logic              frame_done;
    logic              vsync_start;
    logic              rd_en;
    logic [9:0]        rd_x;
    logic [9:0]        rd_y;
    logic [7:0]        pixel_color;
    logic              pixel_valid;
    logic              buffer_using;
    logic              swap_pending;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output wr_valid, wr_x, wr_y, wr_color, frame_done, vsync_start,
               rd_en, rd_x, rd_y, mem_rdata,
        input  wr_ready, pixel_color, pixel_valid, buffer_using, swap_pending,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_color, frame_done, vsync_start,
               rd_en, rd_x, rd_y, mem_rdata,
        output wr_ready, pixel_color, pixel_valid, buffer_using, swap_pending,
               mem_addr, mem_we, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/frame_buffer_ctrl.sv
// ============================================================================
// Module   : frame_buffer_ctrl
// Purpose  : Double-buffered frame-buffer controller: queues drawer writes to
//            the back buffer, serves scan-out reads from the front buffer and
//            swaps buffers on vsync once the drawer has finished its frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_buffer_ctrl #(
    parameter int         FB_W       = 160,
    parameter int         FB_H       = 240,
    parameter int         ADDR_W     = 17,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] BG_COLOR   = 8'h00
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    frame_buffer_ctrl_if.slave bus
);

    localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [9:0]       C_FB_W_10  = 10'(FB_W);
    localparam logic [9:0]       C_FB_H_10  = 10'(FB_H);
    localparam logic [ADDR_W-1:0] C_FB_W_A  = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] C_BUF_OFS = ADDR_W'(FB_W * FB_H);
    localparam logic [PTR_W:0]   C_DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] color;
    } entry_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_swap;
    logic              r_front;

    entry_t            r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    entry_t            w_head;

    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_push;
    logic              w_pop;
    logic              w_rd_issue;

    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;

    logic              r_rd_p1;
    logic              r_rd_oor1;
    logic              r_rd_p2;
    logic              r_rd_oor2;
    logic [7:0]        r_pixel_color;
    logic              r_pixel_valid;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic sel,
                                                   input logic [9:0] x,
                                                   input logic [9:0] y);
        pix_addr = (sel ? C_BUF_OFS : '0) + ADDR_W'(y) * C_FB_W_A + ADDR_W'(x);
    endfunction

    assign w_fifo_empty  = (r_count == '0);
    assign w_fifo_full   = (r_count == C_DEPTH);
    assign w_head        = r_fifo[r_rd_ptr];
    assign w_wr_in_range = (bus.wr_x < C_FB_W_10) && (bus.wr_y < C_FB_H_10);
    assign w_rd_in_range = (bus.rd_x < C_FB_W_10) && (bus.rd_y < C_FB_H_10);

    // Out-of-range writes are still handshaken so the drawer never stalls on them.
    assign bus.wr_ready  = !w_fifo_full && (r_state == ST_IDLE);
    assign w_push        = bus.wr_valid && bus.wr_ready && w_wr_in_range;
    assign w_rd_issue    = bus.rd_en && w_rd_in_range;
    assign w_pop         = !w_rd_issue && !w_fifo_empty;

    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.frame_done) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (bus.vsync_start && w_fifo_empty && !w_pop) begin
                    w_state_next = ST_IDLE;
                    w_swap       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_front <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_swap) begin
                r_front <= ~r_front;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{x: bus.wr_x, y: bus.wr_y, color: bus.wr_color};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The buffer index is sampled here, at issue, so in-flight reads survive a swap.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else if (w_rd_issue) begin
            r_mem_addr  <= pix_addr(r_front, bus.rd_x, bus.rd_y);
            r_mem_we    <= 1'b0;
        end else if (w_pop) begin
            r_mem_addr  <= pix_addr(~r_front, w_head.x, w_head.y);
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_head.color;
        end else begin
            r_mem_we    <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_p1       <= 1'b0;
            r_rd_oor1     <= 1'b0;
            r_rd_p2       <= 1'b0;
            r_rd_oor2     <= 1'b0;
            r_pixel_color <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_rd_p1       <= bus.rd_en;
            r_rd_oor1     <= !w_rd_in_range;
            r_rd_p2       <= r_rd_p1;
            r_rd_oor2     <= r_rd_oor1;
            r_pixel_valid <= r_rd_p2;
            if (r_rd_p2) begin
                r_pixel_color <= r_rd_oor2 ? BG_COLOR : bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.pixel_color  = r_pixel_color;
    assign bus.pixel_valid  = r_pixel_valid;
    assign bus.buffer_using = r_front;
    assign bus.swap_pending = (r_state == ST_PENDING);

endmodule

`default_nettype wire

// File: tb/tb_frame_buffer_ctrl.sv
// ============================================================================
// Module   : tb_frame_buffer_ctrl
// Purpose  : Randomized self-checking bench for frame_buffer_ctrl against a
//            queue/array reference model and a behavioural SRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_frame_buffer_ctrl;

    localparam int         FB_W       = 160;
    localparam int         FB_H       = 240;
    localparam int         ADDR_W     = 17;
    localparam int         FIFO_DEPTH = 8;
    localparam logic [7:0] BG_COLOR   = 8'h00;
    localparam int         MEM_SIZE   = 2 ** ADDR_W;

    logic Clk;
    logic Reset;

    frame_buffer_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    frame_buffer_ctrl #(
        .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH), .BG_COLOR(BG_COLOR)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    logic [7:0] sram [MEM_SIZE];

    always @(posedge Clk) begin
        if (bus.mem_we) begin
            sram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= sram[bus.mem_addr];
    end

    // Reference model: picture image, queue of pending writes, read pipe.
    typedef struct {
        int         x;
        int         y;
        logic [7:0] c;
    } wr_t;

    logic [7:0] img [MEM_SIZE];
    wr_t        q[$];
    bit         m_front;
    bit         m_pending;
    bit         pv [3];
    logic [7:0] pc [3];
    logic [7:0] m_pix;
    bit         exp_we;
    bit         exp_rd;
    int         exp_addr;
    logic [7:0] exp_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int faddr(input bit b, input int x, input int y);
        return (b ? FB_W * FB_H : 0) + y * FB_W + x;
    endfunction

    // One clock: drive at the falling edge, advance the model, check after the next falling edge.
    task automatic step(input bit v, input int wx, input int wy, input logic [7:0] wc,
                        input bit fd, input bit vs, input bit re, input int rx, input int ry,
                        input bit rst);
        bit         ready;
        bit         rd_ok;
        int         n0;
        logic [7:0] new_c;
        wr_t        e;
        bus.wr_valid    = v;
        bus.wr_x        = 10'(wx);
        bus.wr_y        = 10'(wy);
        bus.wr_color    = wc;
        bus.frame_done  = fd;
        bus.vsync_start = vs;
        bus.rd_en       = re;
        bus.rd_x        = 10'(rx);
        bus.rd_y        = 10'(ry);
        Reset           = rst;
        ready = (q.size() < FIFO_DEPTH) && !m_pending;
        #1;
        if (!rst) check("wr_ready", 32'(bus.wr_ready), 32'(ready));

        new_c = BG_COLOR;
        if (rst) begin
            q.delete();
            m_front   = 1'b0;
            m_pending = 1'b0;
            pv        = '{0, 0, 0};
            m_pix     = 8'h00;
            exp_we    = 1'b0;
            exp_rd    = 1'b0;
            exp_addr  = 0;
            exp_wdata = 8'h00;
        end else begin
            n0     = q.size();
            rd_ok  = re && rx < FB_W && ry < FB_H;
            exp_rd = 1'b0;
            exp_we = 1'b0;
            if (rd_ok) begin
                exp_rd   = 1'b1;
                exp_addr = faddr(m_front, rx, ry);
                new_c    = img[exp_addr];
            end else if (n0 > 0) begin
                e         = q.pop_front();
                exp_we    = 1'b1;
                exp_addr  = faddr(!m_front, e.x, e.y);
                exp_wdata = e.c;
                img[exp_addr] = e.c;
            end
            if (v && ready && wx < FB_W && wy < FB_H) begin
                e.x = wx; e.y = wy; e.c = wc;
                q.push_back(e);
            end
            if (!m_pending) begin
                if (fd) m_pending = 1'b1;
            end else if (vs && n0 == 0) begin
                m_pending = 1'b0;
                m_front   = !m_front;
            end
            pv[2] = pv[1]; pc[2] = pc[1];
            pv[1] = pv[0]; pc[1] = pc[0];
            pv[0] = re;    pc[0] = rd_ok ? new_c : BG_COLOR;
            if (pv[2]) m_pix = pc[2];
        end

        @(posedge Clk);
        @(negedge Clk);
        check("mem_we", 32'(bus.mem_we), 32'(exp_we));
        if (exp_we || exp_rd || rst) check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        if (exp_we || rst)           check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
        check("pixel_valid",  32'(bus.pixel_valid), 32'(pv[2]));
        check("pixel_color",  32'(bus.pixel_color), 32'(m_pix));
        check("swap_pending", 32'(bus.swap_pending), 32'(m_pending));
        check("buffer_using", 32'(bus.buffer_using), 32'(m_front));
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_phase(input int n, input int rd_pct, input int rst_pct);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(99) < 70, $urandom_range(179), $urandom_range(259),
                 8'($urandom), $urandom_range(99) < 4, $urandom_range(99) < 8,
                 $urandom_range(99) < rd_pct, $urandom_range(179), $urandom_range(259),
                 $urandom_range(99) < rst_pct);
        end
    endtask

    initial begin
        logic [7:0] val;
        for (int i = 0; i < MEM_SIZE; i++) begin
            val     = 8'($urandom);
            sram[i] = val;
            img[i]  = val;
        end
        Reset = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_color = '0;
        bus.frame_done = 1'b0; bus.vsync_start = 1'b0;
        bus.rd_en = 1'b0; bus.rd_x = '0; bus.rd_y = '0;
        @(negedge Clk);
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        check("rst_fifo_ready", 32'(bus.wr_ready), 32'd1);

        // Single write lands in back buffer 1 one cycle after acceptance.
        step(1, 5, 3, 8'h2C, 0, 0, 0, 0, 0, 0);
        idle();
        check("t1_addr",  32'(bus.mem_addr), 32'd38885);
        check("t1_wdata", 32'(bus.mem_wdata), 32'h2C);

        // Front-buffer read and an out-of-range read.
        sram[161] = 8'h3F;
        img[161]  = 8'h3F;
        step(0, 0, 0, 8'h00, 0, 0, 1, 1, 1, 0);
        idle();
        idle();
        check("t2_pixel", 32'(bus.pixel_color), 32'h3F);
        step(0, 0, 0, 8'h00, 0, 0, 1, 200, 0, 0);
        idle();
        idle();

        // Continuous reads fill the FIFO; release drains it in order.
        for (int i = 0; i < 9; i++) step(1, i, 10, 8'(8'h40 + i), 0, 0, 1, 2, 2, 0);
        for (int i = 0; i < 9; i++) idle();

        // Swap deferred while writes are queued, then taken after the drain.
        for (int i = 0; i < 3; i++) step(1, 20 + i, 7, 8'(8'h80 + i), 0, 0, 1, 3, 3, 0);
        step(0, 0, 0, 8'h00, 1, 0, 1, 3, 3, 0);
        step(0, 0, 0, 8'h00, 0, 1, 1, 3, 3, 0);
        for (int i = 0; i < 4; i++) idle();
        step(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        check("t4_buf", 32'(bus.buffer_using), 32'd1);

        // frame_done with vsync in the same cycle, then a redundant frame_done.
        step(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0);

        // Reset with writes queued and a swap pending.
        for (int i = 0; i < 4; i++) step(1, 30 + i, 9, 8'(i), 0, 0, 1, 4, 4, 0);
        step(0, 0, 0, 8'h00, 1, 0, 1, 4, 4, 0);
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) idle();

        rand_phase(800, 30, 0);
        rand_phase(800, 90, 0);
        rand_phase(800, 60, 1);
        for (int i = 0; i < 10; i++) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
Double-buffered frame-buffer controller that sits between the pixel-drawing engine and a single-port synchronous SRAM. It receives pixel writes (x, y, color) from the drawing engine and stores them into the back buffer. It also serves pixel reads for the VGA scan-out from the front buffer. On a vertical-sync boundary, once the drawer reports its frame as done, it swaps the two buffers and reports the displayed buffer through buffer_using.

Parameters:
FB_W, 160, frame-buffer width in pixels
FB_H, 240, frame-buffer height in pixels
ADDR_W, 17, SRAM address width; must satisfy 2*FB_W*FB_H <= 2^ADDR_W
FIFO_DEPTH, 8, write FIFO entries (power of 2)
BG_COLOR, 8'h00, color returned for out-of-range reads

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
wr_valid  in  1  drawer presents a pixel write
wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
wr_x  in  10  pixel x coordinate
wr_y  in  10  pixel y coordinate
wr_color  in  8  pixel color (RGB332)
frame_done  in  1  single-cycle pulse: drawer finished the back-buffer frame
vsync_start  in  1  single-cycle pulse at start of vertical blank
rd_en  in  1  scan-out pixel request strobe
rd_x  in  10  requested pixel x
rd_y  in  10  requested pixel y
pixel_color  out  8  returned pixel color
pixel_valid  out  1  one-cycle pulse: pixel_color updated
buffer_using  out  1  index of the front (displayed) buffer; back = ~buffer_using
swap_pending  out  1  frame_done received, swap not yet performed
mem_addr  out  ADDR_W  SRAM address (registered)
mem_we  out  1  SRAM write enable (registered)
mem_wdata  out  8  SRAM write data (registered)
mem_rdata  in  8  SRAM read data, valid one cycle after the address

Behaviour:
- Reset values: buffer_using=0, swap_pending=0, FIFO empty, pixel_color=0, pixel_valid=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-operation discards all queued writes and any pending swap.
- wr_ready = !fifo_full && !swap_pending (combinational). The drawer cannot start the next frame until the swap completes.
- An accepted write with wr_x>=FB_W or wr_y>=FB_H is consumed and dropped; it is never pushed.
- Address: addr = (buf ? FB_W*FB_H : 0) + y*FB_W + x, computed in ADDR_W bits. buf is fixed at memory-issue time, not at acceptance time.
- Memory port arbitration, evaluated each edge:
  - If rd_en is high and the read is in range, issue a read of the front buffer (mem_we=0). Reads have priority.
  - Otherwise, if the FIFO is non-empty, pop one entry and issue a write to the back buffer (mem_we=1).
  - Otherwise, mem_we=0.
- Push and pop in the same cycle are allowed. When full, a pop frees space, but wr_ready reflects fullness before the pop.
- Read latency: rd_en sampled at edge N. mem_addr is driven after edge N. mem_rdata is captured into pixel_color at edge N+2, and pixel_valid is high for the cycle following edge N+2. An out-of-range read does not use the port; it returns BG_COLOR with the same 2-cycle latency.
- Back-to-back rd_en on every cycle is legal; writes then stall, the FIFO fills, and wr_ready drops.
- Swap state machine, states IDLE and PENDING:
  - IDLE -> PENDING on frame_done.
  - PENDING -> IDLE on a vsync_start with the FIFO empty and no write issued in that cycle. On that transition, buffer_using toggles.
  - A vsync_start while the FIFO is non-empty defers the swap to a later vsync_start.
  - frame_done while PENDING is ignored.
  - frame_done and vsync_start in the same cycle: go to PENDING; the swap occurs at the next vsync_start, not the current one.
- A read in flight across a swap returns data from the buffer that was addressed when it was issued.

Test Plan:
1. Reset, then write (x=5, y=3, color=8'h2C) with no reads -> one cycle later mem_we=1, mem_addr=38400+3*160+5=38885, mem_wdata=8'h2C; buffer_using=0.
2. Preload SRAM front buffer at addr 161 with 8'h3F, pulse rd_en with (1,1) at edge N -> pixel_color=8'h3F and pixel_valid=1 after edge N+2; a read of (200,0) returns BG_COLOR with no memory access.
3. Hold rd_en high continuously while pushing 9 writes -> wr_ready drops after 8 accepted; release rd_en -> the FIFO drains in 8 cycles at 1 write/cycle in order.
4. Queue 3 writes with reads blocking, pulse frame_done, then pulse vsync_start -> no swap; after drain, next vsync_start -> buffer_using=1, swap_pending=0, wr_ready=1.
5. frame_done and vsync_start in the same cycle -> swap_pending=1, buffer_using unchanged; next vsync_start toggles it. A second frame_done while pending has no effect.
6. Assert Reset with 4 FIFO entries and swap pending -> next cycle: FIFO empty, swap_pending=0, buffer_using=0, no further mem_we pulses.
